// File: rtl/gf180mcu_ocd_io_pkg.sv
// rtl/gf180mcu_ocd_io_pkg.sv - shared constants and state type for the I/O ring config chain
package gf180mcu_ocd_io_pkg;

  localparam int RING_NUM_PADS = 38;
  localparam int RING_CFG_BITS = 8;
  localparam int RING_IDX_W    = 6;

  // Per-pad config byte bit positions
  localparam int CFG_OE    = 7;
  localparam int CFG_IE    = 6;
  localparam int CFG_PDRV1 = 5;
  localparam int CFG_PDRV0 = 4;
  localparam int CFG_SL    = 3;
  localparam int CFG_CS    = 2;
  localparam int CFG_PD    = 1;
  localparam int CFG_PU    = 0;

  // Safe power-up image: pull-down only
  localparam logic [RING_CFG_BITS-1:0] CFG_DEFAULT = RING_CFG_BITS'(1 << CFG_PD);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_FIN
  } ring_state_e;

endpackage

// File: rtl/gf180mcu_ocd_io__cfg_shifter.sv
// rtl/gf180mcu_ocd_io__cfg_shifter.sv - serialises the shadow image onto SDO/SCK, last pad first, MSB first
module gf180mcu_ocd_io__cfg_shifter
  import gf180mcu_ocd_io_pkg::*;
#(
  parameter int NUM_PADS = RING_NUM_PADS,
  parameter int CFG_BITS = RING_CFG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic [RING_IDX_W-1:0] o_rd_idx,
  input  logic [CFG_BITS-1:0]   i_rd_cfg,
  output logic                  o_last,
  output logic                  o_sck,
  output logic                  o_sdo
);

  localparam int NUM_BITS = NUM_PADS * CFG_BITS;
  localparam int CNT_W    = $clog2(NUM_BITS);
  localparam int BIT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

  logic             r_active;
  logic             r_phase_b;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [BIT_W-1:0] w_bit_sel;
  logic             w_next_sdo;

  // The bit for the upcoming phase A is fetched one cycle early so SDO is registered.
  assign w_next_cnt = i_start ? '0 : r_cnt + CNT_W'(1);
  assign o_rd_idx   = RING_IDX_W'(NUM_PADS - 1) - RING_IDX_W'(w_next_cnt[CNT_W-1:BIT_W]);
  assign w_bit_sel  = ~w_next_cnt[BIT_W-1:0];
  assign w_next_sdo = i_rd_cfg[w_bit_sel];
  assign o_last     = r_active && r_phase_b && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_phase_b <= 1'b0;
      r_cnt     <= '0;
      o_sck     <= 1'b0;
      o_sdo     <= 1'b0;
    end else if (i_start) begin
      r_active  <= 1'b1;
      r_phase_b <= 1'b0;
      r_cnt     <= '0;
      o_sck     <= 1'b0;
      o_sdo     <= w_next_sdo;
    end else if (r_active) begin
      if (!r_phase_b) begin
        r_phase_b <= 1'b1;
        o_sck     <= 1'b1;
      end else if (r_cnt == LAST_CNT) begin
        r_active  <= 1'b0;
        r_phase_b <= 1'b0;
        o_sck     <= 1'b0;
        o_sdo     <= 1'b0;
      end else begin
        r_phase_b <= 1'b0;
        r_cnt     <= w_next_cnt;
        o_sck     <= 1'b0;
        o_sdo     <= w_next_sdo;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_ocd_io__ring_cfg.sv
// rtl/gf180mcu_ocd_io__ring_cfg.sv - per-pad shadow config bytes, host write port and chain transfer FSM
module gf180mcu_ocd_io__ring_cfg
  import gf180mcu_ocd_io_pkg::*;
#(
  parameter int NUM_PADS = RING_NUM_PADS,
  parameter int CFG_BITS = RING_CFG_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [RING_IDX_W-1:0] WR_IDX,
  input  logic [CFG_BITS-1:0]   WR_CFG,
  input  logic                  APPLY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  SDO,
  output logic                  SCK,
  output logic                  SLE,
  inout  wire                   VDD,
  inout  wire                   VSS
);

  logic [CFG_BITS-1:0]   r_shadow [NUM_PADS];
  ring_state_e           r_state;
  logic                  r_busy;
  logic                  r_wr_ready;
  logic                  r_done;
  logic                  r_err;
  logic                  r_sle;
  logic                  r_pending;

  logic                  w_wr_fire;
  logic                  w_idx_ok;
  logic                  w_wr_ok;
  logic                  w_start;
  logic                  w_shift_last;
  logic [RING_IDX_W-1:0] w_rd_idx;
  logic [CFG_BITS-1:0]   w_rd_cfg;
  logic                  w_unused_supply;

  assign w_unused_supply = VDD ^ VSS;

  assign w_wr_fire = WR_VALID && r_wr_ready;
  assign w_idx_ok  = WR_IDX < RING_IDX_W'(NUM_PADS);
  assign w_wr_ok   = w_wr_fire && w_idx_ok;
  assign w_start   = (r_state == ST_INIT)
                  || ((r_state == ST_IDLE) && APPLY)
                  || ((r_state == ST_FIN) && (r_pending || APPLY));

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_PADS; i++) r_shadow[i] <= CFG_DEFAULT;
    end else if (w_wr_ok) begin
      r_shadow[WR_IDX] <= WR_CFG;
    end
  end

  // Forward a same-cycle write so a write coinciding with APPLY reaches the first bit.
  always_comb begin
    w_rd_cfg = CFG_DEFAULT;
    if (w_wr_ok && (WR_IDX == w_rd_idx)) w_rd_cfg = WR_CFG;
    else if (w_rd_idx < RING_IDX_W'(NUM_PADS)) w_rd_cfg = r_shadow[w_rd_idx];
  end

  gf180mcu_ocd_io__cfg_shifter #(
    .NUM_PADS (NUM_PADS),
    .CFG_BITS (CFG_BITS)
  ) u_shifter (
    .clk      (CLK),
    .rst      (RST),
    .i_start  (w_start),
    .o_rd_idx (w_rd_idx),
    .i_rd_cfg (w_rd_cfg),
    .o_last   (w_shift_last),
    .o_sck    (SCK),
    .o_sdo    (SDO)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_INIT;
      r_busy     <= 1'b1;
      r_wr_ready <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sle      <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_sle  <= 1'b0;
      r_err  <= w_wr_fire && !w_idx_ok;
      case (r_state)
        ST_INIT: r_state <= ST_SHIFT;
        ST_IDLE: begin
          if (APPLY) begin
            r_state    <= ST_SHIFT;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (APPLY) r_pending <= 1'b1;
          if (w_shift_last) begin
            r_state <= ST_LATCH;
            r_sle   <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (APPLY) r_pending <= 1'b1;
          r_state <= ST_FIN;
          r_done  <= 1'b1;
          // BUSY only stays up through FIN when another transfer follows back to back.
          r_busy  <= r_pending || APPLY;
        end
        ST_FIN: begin
          if (r_pending || APPLY) begin
            r_state   <= ST_SHIFT;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign WR_READY = r_wr_ready;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign SLE      = r_sle;

endmodule

// File: tb/tb_gf180mcu_ocd_io__ring_cfg.sv
// tb/tb_gf180mcu_ocd_io__ring_cfg.sv - directed bench with a bit scoreboard and a ring latch model
module tb_gf180mcu_ocd_io__ring_cfg;
  import gf180mcu_ocd_io_pkg::*;

  localparam int NB = RING_NUM_PADS * RING_CFG_BITS;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_VALID = 1'b0;
  logic       APPLY = 1'b0;
  logic [5:0] WR_IDX = '0;
  logic [7:0] WR_CFG = '0;
  wire        WR_READY, BUSY, DONE, ERR, SDO, SCK, SLE;
  wire        vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_ocd_io__ring_cfg dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_IDX(WR_IDX), .WR_CFG(WR_CFG), .APPLY(APPLY), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .SDO(SDO), .SCK(SCK), .SLE(SLE),
    .VDD(vdd), .VSS(vss)
  );

  always #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_pass  = 0;
  bit          exp_q[$];
  logic [7:0]  model [RING_NUM_PADS];
  logic [NB-1:0] ring_sr  = '0;
  logic [NB-1:0] ring_lat = '0;
  int          sle_cnt = 0;
  int          bit_cnt = 0;
  logic        prev_sck = 1'b0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endfunction

  // Ring model: shift on SCK rise, copy to latches on SLE; each shifted bit is scored.
  always @(negedge CLK) begin
    if (SCK === 1'b1 && prev_sck === 1'b0) begin
      ring_sr = {ring_sr[NB-2:0], SDO};
      bit_cnt++;
      chk("bit_queued", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sdo_bit", 32'(SDO), 32'(exp_q.pop_front()));
    end
    if (SLE === 1'b1) begin
      ring_lat = ring_sr;
      sle_cnt++;
    end
    prev_sck = SCK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_image();
    for (int p = RING_NUM_PADS - 1; p >= 0; p--)
      for (int b = 7; b >= 0; b--) exp_q.push_back(model[p][b]);
  endtask

  task automatic run_to_done(output int sle_cyc, output int done_cyc);
    int cyc;
    cyc = 1;
    sle_cyc = -1;
    done_cyc = -1;
    while (cyc < 2000) begin
      if (SLE === 1'b1) sle_cyc = cyc;
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic do_write(input logic [5:0] idx, input logic [7:0] cfg);
    WR_VALID = 1'b1;
    WR_IDX = idx;
    WR_CFG = cfg;
    chk("wr_ready", 32'(WR_READY), 1);
    step();
    WR_VALID = 1'b0;
    if (idx < RING_NUM_PADS) model[idx] = cfg;
  endtask

  task automatic do_apply();
    APPLY = 1'b1;
    push_image();
    step();
    APPLY = 1'b0;
    chk("apply_busy", 32'(BUSY), 1);
    chk("apply_sck_low", 32'(SCK), 0);
    chk("apply_ready_low", 32'(WR_READY), 0);
  endtask

  task automatic check_ring(input string tag);
    for (int p = 0; p < RING_NUM_PADS; p++) chk(tag, 32'(ring_lat[p*8 +: 8]), 32'(model[p]));
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int s, d, base, sle0, guard;
    for (int p = 0; p < RING_NUM_PADS; p++) model[p] = 8'h02;

    step();
    chk("rst_busy", 32'(BUSY), 1);
    chk("rst_ready", 32'(WR_READY), 0);
    chk("rst_sck", 32'(SCK), 0);
    chk("rst_sdo", 32'(SDO), 0);
    chk("rst_sle", 32'(SLE), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err", 32'(ERR), 0);
    step();
    RST = 1'b0;
    push_image();
    run_to_done(s, d);
    chk("init_sle_cycle", s, 610);
    chk("init_done_cycle", d, 611);
    chk("init_done_busy", 32'(BUSY), 0);
    check_ring("init_ring");
    step();
    chk("idle_ready", 32'(WR_READY), 1);

    do_write(6'd40, 8'hFF);
    chk("err_pulse", 32'(ERR), 1);
    step();
    chk("err_clear", 32'(ERR), 0);
    do_apply();
    run_to_done(s, d);
    chk("apply_sle_cycle", s, 609);
    chk("apply_done_cycle", d, 610);
    check_ring("err_ring");
    step();

    do_write(6'd0, 8'hC1);
    do_write(6'd37, 8'h80);
    do_apply();
    chk("first_sdo", 32'(SDO), 1);
    step();
    chk("phase_b_sck", 32'(SCK), 1);
    run_to_done(s, d);
    chk("first_byte", 32'(ring_lat[NB-1 -: 8]), 32'h80);
    chk("last_byte", 32'(ring_lat[7:0]), 32'hC1);
    check_ring("edit_ring");
    step();

    sle0 = sle_cnt;
    do_apply();
    repeat (50) step();
    APPLY = 1'b1;
    push_image();
    step();
    APPLY = 1'b0;
    repeat (50) step();
    APPLY = 1'b1;
    step();
    APPLY = 1'b0;
    run_to_done(s, d);
    chk("gap_done", 32'(DONE), 1);
    chk("gap_busy_fin", 32'(BUSY), 1);
    step();
    chk("gap_busy_next", 32'(BUSY), 1);
    chk("restart_sck", 32'(SCK), 0);
    run_to_done(s, d);
    chk("pend_sle_cycle", s, 609);
    chk("pend_done_cycle", d, 610);
    chk("pend_busy_fin", 32'(BUSY), 0);
    step();
    chk("pend_ready", 32'(WR_READY), 1);
    repeat (20) step();
    chk("pend_no_third", 32'(BUSY), 0);
    chk("pend_sle_count", sle_cnt - sle0, 2);
    check_ring("pend_ring");

    sle0 = sle_cnt;
    do_apply();
    base = bit_cnt;
    guard = 0;
    while ((bit_cnt - base) < 100 && guard < 1000) begin
      step();
      guard++;
    end
    chk("abort_at_bit", bit_cnt - base, 100);
    RST = 1'b1;
    step();
    exp_q.delete();
    for (int p = 0; p < RING_NUM_PADS; p++) model[p] = 8'h02;
    chk("abort_busy", 32'(BUSY), 1);
    chk("abort_sck", 32'(SCK), 0);
    chk("abort_no_sle", sle_cnt - sle0, 0);
    RST = 1'b0;
    push_image();
    run_to_done(s, d);
    chk("reinit_sle_cycle", s, 610);
    chk("reinit_done_cycle", d, 611);
    chk("reinit_sle_count", sle_cnt - sle0, 1);
    check_ring("reinit_ring");
    step();

    WR_VALID = 1'b1;
    WR_IDX = 6'd5;
    WR_CFG = 8'h3C;
    APPLY = 1'b1;
    model[5] = 8'h3C;
    push_image();
    chk("coin_ready", 32'(WR_READY), 1);
    step();
    WR_VALID = 1'b0;
    APPLY = 1'b0;
    chk("coin_busy", 32'(BUSY), 1);
    run_to_done(s, d);
    chk("coin_done_cycle", d, 610);
    chk("coin_pad5", 32'(ring_lat[5*8 +: 8]), 32'h3C);
    check_ring("coin_ring");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
